// File: rtl/seq1011_ctx_if.sv
// Channel-side and detection-side signal bundle for the shared "1011" detector.
// The master drives the serial channels and observes detection results.
// The slave is the scheduler itself.
interface seq1011_ctx_if #(
  parameter int NCH  = 4,
  parameter int CNTW = 16
);
  localparam int IW = $clog2(NCH);

  logic            enable;
  logic [NCH-1:0]  ch_valid;
  logic [NCH-1:0]  ch_x;
  logic [NCH-1:0]  ch_clr;
  logic [NCH-1:0]  ch_ready;
  logic            det_valid;
  logic [IW-1:0]   det_ch;
  logic            det_hit;
  logic [CNTW-1:0] hit_cnt;

  modport master (
    output enable, ch_valid, ch_x, ch_clr,
    input  ch_ready, det_valid, det_ch, det_hit, hit_cnt
  );

  modport slave (
    input  enable, ch_valid, ch_x, ch_clr,
    output ch_ready, det_valid, det_ch, det_hit, hit_cnt
  );
endinterface

// File: rtl/seq1011_ctx_scheduler.sv
// Time-multiplexed Mealy "1011" detector (non-overlapping) shared by NCH serial
// channels. Each channel owns a 2-bit context. A round-robin arbiter picks one
// channel bit per clock. The results and a saturating hit counter are registered.
module seq1011_ctx_scheduler #(
  parameter int NCH  = 4,
  parameter int CNTW = 16
) (
  input logic         clk,
  input logic         reset,
  seq1011_ctx_if.slave bus
);
  localparam int IW = $clog2(NCH);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  // The returned value is {hit, next_state} for one detector step.
  function automatic logic [2:0] step_fn(input state_t s, input logic x);
    logic [2:0] r;
    case (s)
      S0:      r = x ? {1'b0, S1} : {1'b0, S0};
      S1:      r = x ? {1'b0, S1} : {1'b0, S2};
      S2:      r = x ? {1'b0, S3} : {1'b0, S0};
      S3:      r = x ? {1'b1, S0} : {1'b0, S2};
      default: r = {1'b0, S0};
    endcase
    return r;
  endfunction

  state_t          ctx_r [NCH];
  logic [IW-1:0]   rr_ptr_r;
  logic            det_valid_r;
  logic [IW-1:0]   det_ch_r;
  logic            det_hit_r;
  logic [CNTW-1:0] hit_cnt_r;

  logic [NCH-1:0]  eligible_s;
  logic            found_s;
  logic [IW-1:0]   gidx_s;
  logic [NCH-1:0]  grant_s;
  logic            accept_s;
  logic [2:0]      step_s;
  state_t          nxt_s;
  logic            hit_s;

  assign eligible_s = bus.ch_valid & ~bus.ch_clr;

  // Round-robin search starting after the last granted channel. The result is gated
  // by enable and by reset so that no grant is issued while reset is asserted.
  always_comb begin
    logic [IW:0] cand_v;
    found_s = 1'b0;
    gidx_s  = {IW{1'b0}};
    grant_s = {NCH{1'b0}};
    cand_v  = {(IW+1){1'b0}};
    for (int k = 1; k <= NCH; k++) begin
      cand_v = {1'b0, rr_ptr_r} + (IW+1)'(k);
      if (cand_v >= (IW+1)'(NCH)) begin
        cand_v = cand_v - (IW+1)'(NCH);
      end else begin
        cand_v = cand_v;
      end
      if (!found_s && eligible_s[cand_v[IW-1:0]]) begin
        found_s = 1'b1;
        gidx_s  = cand_v[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
    if (found_s && bus.enable && reset) begin
      grant_s[gidx_s] = 1'b1;
    end else begin
      grant_s = {NCH{1'b0}};
    end
  end

  assign accept_s = |grant_s;

  // Shared Mealy datapath: one step of the selected channel's context.
  always_comb begin
    step_s = step_fn(ctx_r[gidx_s], bus.ch_x[gidx_s]);
    hit_s  = step_s[2];
    nxt_s  = state_t'(step_s[1:0]);
  end

  // Context file, arbiter pointer, detection result registers and hit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_r[i] <= S0;
      end
      rr_ptr_r    <= IW'(NCH - 1);
      det_valid_r <= 1'b0;
      det_ch_r    <= {IW{1'b0}};
      det_hit_r   <= 1'b0;
      hit_cnt_r   <= {CNTW{1'b0}};
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.ch_clr[i]) begin
          ctx_r[i] <= S0;
        end else if (grant_s[i]) begin
          ctx_r[i] <= nxt_s;
        end
      end
      det_valid_r <= accept_s;
      if (accept_s) begin
        rr_ptr_r  <= gidx_s;
        det_ch_r  <= gidx_s;
        det_hit_r <= hit_s;
      end
      if (det_valid_r && det_hit_r && (hit_cnt_r != {CNTW{1'b1}})) begin
        hit_cnt_r <= hit_cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.ch_ready  = grant_s;
  assign bus.det_valid = det_valid_r;
  assign bus.det_ch    = det_ch_r;
  assign bus.det_hit   = det_hit_r;
  assign bus.hit_cnt   = hit_cnt_r;
endmodule

// File: tb/tb_seq1011_ctx_scheduler.sv
// Directed bench for seq1011_ctx_scheduler: instance A (NCH=4, CNTW=16) covers
// arbitration, detection, and clearing. Instance B (NCH=4, CNTW=2) covers
// saturation and enable gaps.
module tb_seq1011_ctx_scheduler;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  seq1011_ctx_if #(.NCH(4), .CNTW(16)) a_if ();
  seq1011_ctx_if #(.NCH(4), .CNTW(2))  b_if ();

  seq1011_ctx_scheduler #(.NCH(4), .CNTW(16)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  seq1011_ctx_scheduler #(.NCH(4), .CNTW(2))  dut_b (.clk(clk), .reset(reset), .bus(b_if));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [3:0] v, input logic [3:0] x, input logic [3:0] clr);
    a_if.ch_valid = v;
    a_if.ch_x     = x;
    a_if.ch_clr   = clr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_if.enable = 1'b1; b_if.enable = 1'b1;
    drive_a(4'b0000, 4'b0000, 4'b0000);
    b_if.ch_valid = 4'b0000; b_if.ch_x = 4'b0000; b_if.ch_clr = 4'b0000;
    #2 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_a(4'($urandom) | 4'b0001, 4'($urandom), 4'($urandom) & 4'b1110);
      b_if.ch_valid = 4'b1111; b_if.ch_x = 4'($urandom);
      #1;
      checks++;
      if (a_if.ch_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_ready_a: got %b want 0000", a_if.ch_ready);
      end
      checks++;
      if (b_if.ch_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_ready_b: got %b want 0000", b_if.ch_ready);
      end
      cyc();
      checks++;
      if (a_if.det_valid !== 1'b0 || a_if.hit_cnt !== 16'd0) begin
        errors++; $display("FAIL reset_regs: det_valid=%b hit_cnt=%0d want 0,0", a_if.det_valid, a_if.hit_cnt);
      end
    end
    checks++;
    if (a_if.det_ch !== 2'd0 || a_if.det_hit !== 1'b0 || b_if.hit_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_det: det_ch=%0d det_hit=%b b_cnt=%0d want 0,0,0", a_if.det_ch, a_if.det_hit, b_if.hit_cnt);
    end
    drive_a(4'b1111, 4'b0000, 4'b0000);
    b_if.ch_valid = 4'b0000;
    reset = 1'b1;
    #1;
    checks++;
    if (a_if.ch_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant: got %b want 0001", a_if.ch_ready);
    end
    drive_a(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_single();
    logic sq [7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic hit [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive_a(4'b0001, {3'b000, sq[i]}, 4'b0000);
      #1;
      checks++;
      if (a_if.ch_ready !== 4'b0001) begin
        errors++; $display("FAIL single_ready[%0d]: got %b want 0001", i, a_if.ch_ready);
      end
      cyc();
      checks++;
      if (a_if.det_valid !== 1'b1 || a_if.det_ch !== 2'd0 || a_if.det_hit !== hit[i]) begin
        errors++; $display("FAIL single_det[%0d]: v=%b ch=%0d hit=%b want 1,0,%b", i, a_if.det_valid, a_if.det_ch, a_if.det_hit, hit[i]);
      end
    end
    drive_a(4'b0000, 4'b0000, 4'b0000);
    cyc();
    checks++;
    if (a_if.det_valid !== 1'b0 || a_if.det_ch !== 2'd0 || a_if.det_hit !== 1'b0 || a_if.hit_cnt !== 16'd1) begin
      errors++; $display("FAIL single_idle: v=%b ch=%0d hit=%b cnt=%0d want 0,0,0,1", a_if.det_valid, a_if.det_ch, a_if.det_hit, a_if.hit_cnt);
    end
  endtask

  task automatic test_interleave();
    logic s4 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int p0 = 0;
    int p1 = 0;
    logic b0, b1;
    logic [3:0] exp_rdy;
    // Clear ch0/ch1 contexts and grant ch3 one 0-bit so that ch0 is searched first next.
    drive_a(4'b1000, 4'b0000, 4'b0011);
    #1;
    checks++;
    if (a_if.ch_ready !== 4'b1000) begin
      errors++; $display("FAIL prep_ready: got %b want 1000", a_if.ch_ready);
    end
    cyc();
    checks++;
    if (a_if.det_valid !== 1'b1 || a_if.det_ch !== 2'd3 || a_if.det_hit !== 1'b0) begin
      errors++; $display("FAIL prep_det: v=%b ch=%0d hit=%b want 1,3,0", a_if.det_valid, a_if.det_ch, a_if.det_hit);
    end
    for (int k = 0; k < 8; k++) begin
      b0 = (p0 < 4) ? s4[p0] : 1'b0;
      b1 = (p1 < 4) ? s4[p1] : 1'b0;
      drive_a(4'b0011, {2'b00, b1, b0}, 4'b0000);
      exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      #1;
      checks++;
      if (a_if.ch_ready !== exp_rdy) begin
        errors++; $display("FAIL inter_ready[%0d]: got %b want %b", k, a_if.ch_ready, exp_rdy);
      end
      cyc();
      checks++;
      if (a_if.det_valid !== 1'b1 || a_if.det_ch !== 2'(k % 2) || a_if.det_hit !== (k >= 6)) begin
        errors++; $display("FAIL inter_det[%0d]: v=%b ch=%0d hit=%b want 1,%0d,%b", k, a_if.det_valid, a_if.det_ch, a_if.det_hit, k % 2, (k >= 6));
      end
      if (k % 2 == 0) p0++; else p1++;
    end
    drive_a(4'b0000, 4'b0000, 4'b0000);
    cyc();
    checks++;
    if (a_if.hit_cnt !== 16'd3) begin
      errors++; $display("FAIL inter_cnt: got %0d want 3", a_if.hit_cnt);
    end
  endtask

  task automatic test_overlap();
    logic s6 [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive_a(4'b0100, {1'b0, s6[i], 2'b00}, 4'b0000);
      #1;
      checks++;
      if (a_if.ch_ready !== 4'b0100) begin
        errors++; $display("FAIL overlap_ready[%0d]: got %b want 0100", i, a_if.ch_ready);
      end
      cyc();
      checks++;
      if (a_if.det_valid !== 1'b1 || a_if.det_ch !== 2'd2 || a_if.det_hit !== (i == 5)) begin
        errors++; $display("FAIL overlap_det[%0d]: v=%b ch=%0d hit=%b want 1,2,%b", i, a_if.det_valid, a_if.det_ch, a_if.det_hit, (i == 5));
      end
    end
    drive_a(4'b0000, 4'b0000, 4'b0000);
    cyc();
    checks++;
    if (a_if.hit_cnt !== 16'd4) begin
      errors++; $display("FAIL overlap_cnt: got %0d want 4", a_if.hit_cnt);
    end
  endtask

  task automatic test_clear_collision();
    logic s3 [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive_a(4'b0010, {2'b00, s3[i], 1'b0}, 4'b0000);
      cyc();
      checks++;
      if (a_if.det_valid !== 1'b1 || a_if.det_ch !== 2'd1 || a_if.det_hit !== 1'b0) begin
        errors++; $display("FAIL clr_prep[%0d]: v=%b ch=%0d hit=%b want 1,1,0", i, a_if.det_valid, a_if.det_ch, a_if.det_hit);
      end
    end
    // ch1 sits in S3. The clear must mask its grant while ch3 still wins arbitration.
    drive_a(4'b1010, 4'b0010, 4'b0010);
    #1;
    checks++;
    if (a_if.ch_ready !== 4'b1000) begin
      errors++; $display("FAIL clr_mask_ready: got %b want 1000", a_if.ch_ready);
    end
    cyc();
    checks++;
    if (a_if.det_valid !== 1'b1 || a_if.det_ch !== 2'd3 || a_if.det_hit !== 1'b0) begin
      errors++; $display("FAIL clr_mask_det: v=%b ch=%0d hit=%b want 1,3,0", a_if.det_valid, a_if.det_ch, a_if.det_hit);
    end
    drive_a(4'b0010, 4'b0010, 4'b0000);
    #1;
    checks++;
    if (a_if.ch_ready !== 4'b0010) begin
      errors++; $display("FAIL clr_after_ready: got %b want 0010", a_if.ch_ready);
    end
    cyc();
    checks++;
    if (a_if.det_valid !== 1'b1 || a_if.det_ch !== 2'd1 || a_if.det_hit !== 1'b0) begin
      errors++; $display("FAIL clr_after_det: v=%b ch=%0d hit=%b want 1,1,0", a_if.det_valid, a_if.det_ch, a_if.det_hit);
    end
    drive_a(4'b0000, 4'b0000, 4'b0000);
    cyc();
    checks++;
    if (a_if.hit_cnt !== 16'd4) begin
      errors++; $display("FAIL clr_cnt: got %0d want 4", a_if.hit_cnt);
    end
  endtask

  task automatic test_sat_enable();
    logic s4 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 20; i++) begin
      if (i == 4) begin
        b_if.enable   = 1'b0;
        b_if.ch_valid = 4'b0001;
        b_if.ch_x     = {3'b000, s4[0]};
        for (int d = 0; d < 3; d++) begin
          #1;
          checks++;
          if (b_if.ch_ready !== 4'b0000) begin
            errors++; $display("FAIL dis_ready[%0d]: got %b want 0000", d, b_if.ch_ready);
          end
          cyc();
          checks++;
          if (b_if.det_valid !== 1'b0 || b_if.det_hit !== 1'b1 || b_if.hit_cnt !== 2'd1) begin
            errors++; $display("FAIL dis_det[%0d]: v=%b hit=%b cnt=%0d want 0,1,1", d, b_if.det_valid, b_if.det_hit, b_if.hit_cnt);
          end
        end
        b_if.enable = 1'b1;
      end
      b_if.ch_valid = 4'b0001;
      b_if.ch_x     = {3'b000, s4[i % 4]};
      #1;
      checks++;
      if (b_if.ch_ready !== 4'b0001) begin
        errors++; $display("FAIL sat_ready[%0d]: got %b want 0001", i, b_if.ch_ready);
      end
      cyc();
      checks++;
      if (b_if.det_valid !== 1'b1 || b_if.det_ch !== 2'd0 || b_if.det_hit !== (i % 4 == 3)) begin
        errors++; $display("FAIL sat_det[%0d]: v=%b ch=%0d hit=%b want 1,0,%b", i, b_if.det_valid, b_if.det_ch, b_if.det_hit, (i % 4 == 3));
      end
    end
    b_if.ch_valid = 4'b0000;
    cyc();
    cyc();
    checks++;
    if (b_if.hit_cnt !== 2'd3) begin
      errors++; $display("FAIL sat_cnt: got %0d want 3", b_if.hit_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_overlap();
    test_clear_collision();
    test_sat_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
